cameralink_uart_phy: RTL
========================

// Module: cameralink_uart_phy
// PURPOSE
// - Camera Link serial PHY: 8N1 UART transmitter (SerTC, to camera) and receiver (SerTFG, from camera).
// - Sits directly downstream of the AXI-to-UART register block.
// - Consumes its tx_start/tx_data pulses and produces its tx_busy/rx_ready/rx_data.
// - A TX FIFO absorbs AXI burst writes, because the upstream block pulses tx_start on every beat without checking tx_busy.
// PARAMETERS
// CLK_FREQ       100_000_000  s_axi_aclk frequency in Hz
// BAUD_RATE      9600         serial rate in bit/s; Camera Link default
// TX_FIFO_DEPTH  16           TX byte FIFO depth; power of 2, >= 2
// (localparam) CYCLES_PER_BIT = CLK_FREQ / BAUD_RATE, integer-truncated; must be >= 4
// PORTS
// s_axi_aclk      in   1  single clock for the whole block
// s_axi_areset    in   1  synchronous reset, active-high
// tx_start        in   1  1-cycle pulse: push tx_data into the TX FIFO
// tx_data         in   8  byte to transmit, valid with tx_start
// tx_busy         out  1  high while the FIFO is non-empty or the shifter is active
// tx_overflow     out  1  sticky: a tx_start was dropped because the FIFO was full; cleared only by reset
// rx_ready        out  1  1-cycle pulse: rx_data holds a new, correctly framed byte
// rx_data         out  8  last received byte; held until the next valid byte
// rx_frame_error  out  1  1-cycle pulse: stop bit sampled low; byte discarded
// ser_tc          out  1  serial TX line; idle high
// ser_tfg         in   1  serial RX line; asynchronous, idle high
// BEHAVIOUR
// - Reset values: ser_tc=1, tx_busy=0, tx_overflow=0, rx_ready=0, rx_data=0, rx_frame_error=0.
// - Reset also: FIFO empty, both FSMs idle, all counters 0.
// - Reset mid-frame: abort at the next edge; ser_tc returns high; FIFO contents and any partial RX byte are lost.
// - Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly CYCLES_PER_BIT clocks.
// - FIFO write:
//   - tx_start with FIFO not full: write at the edge; tx_busy is high from the next cycle.
//   - tx_start with FIFO full: byte dropped, tx_overflow set.
//   - Exception: a write in the same cycle as a pop is accepted (count unchanged).
// - TX FSM states: TX_IDLE, TX_START, TX_DATA, TX_STOP.
//   - TX_IDLE -> TX_START when the FIFO is non-empty: pop into the shift reg, ser_tc=0, bit counter cleared (1-cycle pop latency).
//   - Bit counter counts 0..CYCLES_PER_BIT-1; at terminal count, advance to the next bit.
//   - TX_DATA shifts 8 times (3-bit index). TX_STOP drives 1 for one full bit, then returns to TX_IDLE.
//   - Back-to-back bytes: the next start bit immediately follows the stop bit; no extra idle cycle.
//   - tx_busy deasserts the cycle after TX_STOP completes if the FIFO is empty.
// - RX input: ser_tfg passes through a 2-FF synchronizer. Edge detection uses sync stage 2 vs stage 3.
// - RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
//   - RX_IDLE -> RX_START on a falling edge; counter cleared.
//   - RX_START: at count CYCLES_PER_BIT/2 - 1, sample the line.
//     - Sample high: false start; return to RX_IDLE with no pulse.
//     - Sample low: go to RX_DATA, counter cleared.
//   - RX_DATA: sample at each CYCLES_PER_BIT terminal count, 8 bits LSB first. Then go to RX_STOP.
//   - RX_STOP: sample after one more bit time.
//     - Sample 1: rx_data updated and rx_ready pulsed in the same cycle.
//     - Sample 0: rx_frame_error pulsed; rx_data unchanged.
//     - Either way, go to RX_IDLE (ready for a new start edge the next cycle).
// - TX and RX are fully independent. Simultaneous TX/RX and loopback (ser_tc tied to ser_tfg) must work.
// - RX has no buffering. Upstream latches on rx_ready; bytes are never back-pressured.
// STRUCTURE
// - Package cameralink_uart_pkg:
//   - tx_state_t and rx_state_t enums.
//   - UART_START_BIT=1'b0, UART_STOP_BIT=1'b1, UART_DATA_BITS=8.
// - Sub-module cameralink_uart_fifo: synchronous FIFO.
//   - Parameters DEPTH and WIDTH=8; ports wr_en, din, rd_en, dout, full, empty.
//   - Registered read, one-cycle latency; simultaneous rd/wr when full is allowed.
// - TX/RX FSMs, bit counters, and the synchronizer live in the top module.
// TESTING (bench uses CLK_FREQ=1_000_000, BAUD_RATE=100_000 -> 10 clocks/bit, 100 clocks/frame)
// - Single TX: tx_start with 0xA5 -> ser_tc = 0,1,0,1,0,0,1,0,1,1, each bit 10 clocks. tx_busy high for 1+100 clocks, then low.
// - Burst: 16 tx_start pulses on consecutive cycles (0x00..0x0F) -> 16 gapless frames in order, tx_overflow=0.
//   - 18 pulses -> tx_overflow=1, and exactly 17 frames sent (one pop overlaps the burst).
// - RX: drive 0x3C frame on ser_tfg -> one rx_ready pulse with rx_data=0x3C, about 3+95 clocks after the start edge.
//   - Then drive stop=0 -> rx_frame_error pulse, no rx_ready, rx_data stays 0x3C.
// - Glitch: ser_tfg low for 3 clocks -> no rx_ready, no rx_frame_error; FSM back in RX_IDLE.
// - Loopback: ser_tc->ser_tfg, send 0x55,0xFF,0x00 -> rx_ready x3 with the same bytes.
// - Reset mid-frame: assert s_axi_areset at bit 4 of a TX frame -> ser_tc=1 next cycle, tx_busy=0, FIFO empty.
//   - First frame after release is the next new tx_start byte.

Source files
------------

// File: rtl/cameralink_uart_pkg.sv
// Shared types and constants for the Camera Link serial PHY.
//   tx_state_t / rx_state_t : FSM encodings, also exported on debug ports
//   UART_START_BIT, UART_STOP_BIT, UART_DATA_BITS : 8N1 framing constants
package cameralink_uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam int   UART_DATA_BITS = 8;

endpackage

// File: rtl/cameralink_uart_fifo.sv
// Synchronous byte FIFO with a registered read port.
//   clk, rst : clock, synchronous active-high reset
//   wr_en/din: write request; ignored when full unless a read happens in the same cycle
//   rd_en    : pop request; ignored when empty
//   dout     : popped word, valid the cycle after rd_en, held until the next pop
//   full/empty : occupancy flags
module cameralink_uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             wr_ok, rd_ok;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign dout  = dout_q;

  always_comb begin
    rd_ok    = rd_en && !empty;
    // A pop in the same cycle frees a slot, so a write against a full FIFO still lands.
    wr_ok    = wr_en && (!full || rd_ok);
    wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    dout_d   = rd_ok ? mem_q[rd_ptr_q] : dout_q;
    count_d  = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (!wr_ok && rd_ok) begin
      count_d = count_q - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/cameralink_uart_phy.sv
// Camera Link serial PHY: 8N1 UART transmitter on ser_tc, receiver on ser_tfg.
//   s_axi_aclk, s_axi_areset : clock, synchronous active-high reset
//   tx_start/tx_data : push one byte into the TX FIFO (no ready; drops set tx_overflow)
//   tx_busy          : FIFO non-empty or a frame in flight
//   tx_overflow      : sticky, a push was dropped on a full FIFO
//   rx_ready/rx_data : 1-cycle pulse with a correctly framed byte; rx_data held
//   rx_frame_error   : 1-cycle pulse, stop bit sampled low, byte discarded
//   ser_tc / ser_tfg : serial lines, idle high; ser_tfg is asynchronous
//   tx_state_dbg / rx_state_dbg : current FSM states
// Handshake: tx_start is a valid with an implied always-ready sink; a push that
// finds the FIFO full (and no pop that cycle) is lost and flagged. rx_ready is a
// valid with no back-pressure; the consumer must take rx_data on the pulse.
module cameralink_uart_phy
  import cameralink_uart_pkg::*;
#(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int BAUD_RATE     = 9600,
  parameter int TX_FIFO_DEPTH = 16
) (
  input  logic       s_axi_aclk,
  input  logic       s_axi_areset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_overflow,
  output logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_frame_error,
  output logic       ser_tc,
  input  logic       ser_tfg,
  output tx_state_t  tx_state_dbg,
  output rx_state_t  rx_state_dbg
);

  localparam int CYCLES_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF  = CW'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [2:0]    LAST_DATA = 3'(UART_DATA_BITS - 1);

  // ---------------- TX path ----------------
  logic       fifo_rd, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;

  cameralink_uart_fifo #(.DEPTH(TX_FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk  (s_axi_aclk),
    .rst  (s_axi_areset),
    .wr_en(tx_start),
    .din  (tx_data),
    .rd_en(fifo_rd),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  tx_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          ser_tc_q, ser_tc_d;
  logic          tx_ovf_q, tx_ovf_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CW'(1);
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    fifo_rd    = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_rd    = 1'b1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        // The popped byte appears on fifo_dout one cycle after the pop,
        // well before the start bit ends.
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = fifo_dout;
          tx_idx_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == LAST_DATA) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_idx_d   = tx_idx_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit when more bytes are queued.
          if (!fifo_empty) begin
            fifo_rd    = 1'b1;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // Line level is registered from the next state so ser_tc is glitch-free.
    unique case (tx_state_d)
      TX_START: ser_tc_d = UART_START_BIT;
      TX_DATA:  ser_tc_d = tx_shift_d[0];
      default:  ser_tc_d = UART_STOP_BIT;
    endcase

    tx_ovf_d = tx_ovf_q | (tx_start && fifo_full && !fifo_rd);
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      ser_tc_q   <= UART_STOP_BIT;
      tx_ovf_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      ser_tc_q   <= ser_tc_d;
      tx_ovf_q   <= tx_ovf_d;
    end
  end

  assign ser_tc       = ser_tc_q;
  assign tx_overflow  = tx_ovf_q;
  assign tx_busy      = !fifo_empty || (tx_state_q != TX_IDLE);
  assign tx_state_dbg = tx_state_q;

  // ---------------- RX path ----------------
  // sync_q[1] is the synchronized line; sync_q[2] is its previous value.
  logic [2:0]    sync_q, sync_d;
  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_ready_q, rx_ready_d;
  logic          rx_fe_q, rx_fe_d;
  logic          rx_line, rx_fall;

  always_comb begin
    sync_d     = {sync_q[1:0], ser_tfg};
    rx_line    = sync_q[1];
    rx_fall    = sync_q[2] & ~sync_q[1];
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_ready_d = 1'b0;
    rx_fe_d    = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) begin
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        // Re-check the line mid start bit to reject short glitches.
        if (rx_cnt_q == BIT_HALF) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_line ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_line, rx_shift_q[7:1]};
          if (rx_idx_q == LAST_DATA) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_line == UART_STOP_BIT) begin
            rx_data_d  = rx_shift_q;
            rx_ready_d = 1'b1;
          end else begin
            rx_fe_d = 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      sync_q     <= 3'b111;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_ready_q <= 1'b0;
      rx_fe_q    <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_ready_q <= rx_ready_d;
      rx_fe_q    <= rx_fe_d;
    end
  end

  assign rx_data        = rx_data_q;
  assign rx_ready       = rx_ready_q;
  assign rx_frame_error = rx_fe_q;
  assign rx_state_dbg   = rx_state_q;

endmodule
